// File: rtl/altpcierd_irq_msi_gen.sv
`default_nettype none
// ============================================================================
//  Module      : altpcierd_irq_msi_gen
//  Description : Interrupt requester. Latches per-source interrupt pulses and
//                forwards them to the PCIe Hard IP as MSI (req/ack) when MSI
//                and bus mastering are enabled, else as legacy INTx.
//  Revision    : 1.0 - initial release
// ============================================================================
module altpcierd_irq_msi_gen #(
    parameter int NUM_SRC    = 4,
    parameter int MSI_TC     = 0,
    parameter int GAP_CYCLES = 4
) (
    input  logic               pld_clk,
    input  logic               rstn,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [NUM_SRC-1:0] irq_clr,
    input  logic [15:0]        cfg_msicsr,
    input  logic [15:0]        cfg_prmcsr,
    output logic               app_msi_req,
    input  logic               app_msi_ack,
    output logic [4:0]         app_msi_num,
    output logic [2:0]         app_msi_tc,
    output logic               app_int_sts,
    input  logic               app_int_ack,
    output logic [NUM_SRC-1:0] irq_pending,
    output logic [15:0]        msi_sent_cnt
);

    localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [2:0] {
        S_IDLE          = 3'd0,
        S_MSI_REQ       = 3'd1,
        S_MSI_GAP       = 3'd2,
        S_INTX_ASSERT   = 3'd3,
        S_INTX_ON       = 3'd4,
        S_INTX_DEASSERT = 3'd5
    } state_t;

    state_t             r_state;
    logic [NUM_SRC-1:0] r_pending;
    logic [SW-1:0]      r_rr_ptr;
    logic [SW-1:0]      r_sel;
    logic [7:0]         r_gap_cnt;
    logic               r_msi_req;
    logic [4:0]         r_msi_num;
    logic               r_int_sts;
    logic [15:0]        r_cnt;

    logic               w_msi_mode;
    logic               w_intx_ok;
    logic               w_any;
    logic               w_msi_ack;
    logic [NUM_SRC-1:0] w_clr;
    logic [2:0]         w_mme;
    logic [4:0]         w_alloc_m1;
    logic               w_found;
    logic [SW-1:0]      w_sel;
    logic [SW:0]        w_idx;
    logic [4:0]         w_sel5;
    logic [4:0]         w_vec;
    logic [SW-1:0]      w_rr_next;
    logic               w_unused_cfg;

    assign w_msi_mode = cfg_msicsr[0] & cfg_prmcsr[2];
    assign w_intx_ok  = ~w_msi_mode & ~cfg_prmcsr[10];
    assign w_any      = |r_pending;
    assign w_msi_ack  = (r_state == S_MSI_REQ) & app_msi_ack;
    assign w_clr      = irq_clr | (w_msi_ack ? (NUM_SRC'(1) << r_sel) : '0);
    assign w_mme      = cfg_msicsr[6:4];

    // Config bits this block does not look at, folded so they are visibly consumed
    assign w_unused_cfg = ^{cfg_msicsr[15:7], cfg_msicsr[3:1],
                            cfg_prmcsr[15:11], cfg_prmcsr[9:3], cfg_prmcsr[1:0]};

    // Highest vector index granted by MME; MME above 5 saturates at 32 vectors
    always_comb begin
        w_alloc_m1 = 5'd31;
        case (w_mme)
            3'd0:    w_alloc_m1 = 5'd0;
            3'd1:    w_alloc_m1 = 5'd1;
            3'd2:    w_alloc_m1 = 5'd3;
            3'd3:    w_alloc_m1 = 5'd7;
            3'd4:    w_alloc_m1 = 5'd15;
            default: w_alloc_m1 = 5'd31;
        endcase
    end

    // Round-robin pick: first pending source at or after rr_ptr, wrapping
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_rr_ptr;
        w_idx   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (SW+1)'(k);
            if (w_idx >= (SW+1)'(NUM_SRC)) begin
                w_idx = w_idx - (SW+1)'(NUM_SRC);
            end
            if (!w_found && r_pending[w_idx[SW-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_idx[SW-1:0];
            end
        end
    end

    assign w_sel5    = 5'(w_sel);
    assign w_vec     = (w_sel5 > w_alloc_m1) ? w_alloc_m1 : w_sel5;
    assign w_rr_next = (r_sel == SW'(NUM_SRC - 1)) ? '0 : r_sel + SW'(1);

    // Pending bits: a new event in the same cycle outranks any clear
    always_ff @(posedge pld_clk or negedge rstn) begin
        if (!rstn) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | irq_src;
        end
    end

    // Request FSM: MSI handshake with post-ack gap, or INTx assert/deassert handshake
    always_ff @(posedge pld_clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_rr_ptr  <= '0;
            r_sel     <= '0;
            r_gap_cnt <= '0;
            r_msi_req <= 1'b0;
            r_msi_num <= '0;
            r_int_sts <= 1'b0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_msi_mode && w_any) begin
                        r_sel     <= w_sel;
                        r_msi_num <= w_vec;
                        r_msi_req <= 1'b1;
                        r_state   <= S_MSI_REQ;
                    end else if (w_intx_ok && w_any) begin
                        r_int_sts <= 1'b1;
                        r_state   <= S_INTX_ASSERT;
                    end
                end
                // A posted request is never withdrawn, whatever the config does
                S_MSI_REQ: begin
                    if (app_msi_ack) begin
                        r_msi_req <= 1'b0;
                        r_cnt     <= r_cnt + 16'd1;
                        r_rr_ptr  <= w_rr_next;
                        r_gap_cnt <= 8'(GAP_CYCLES);
                        r_state   <= S_MSI_GAP;
                    end
                end
                S_MSI_GAP: begin
                    if (r_gap_cnt == 8'd0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 8'd1;
                    end
                end
                S_INTX_ASSERT: begin
                    if (app_int_ack) begin
                        r_state <= S_INTX_ON;
                    end
                end
                S_INTX_ON: begin
                    if (!(w_any && w_intx_ok)) begin
                        r_int_sts <= 1'b0;
                        r_state   <= S_INTX_DEASSERT;
                    end
                end
                S_INTX_DEASSERT: begin
                    if (app_int_ack) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_msi_req <= 1'b0;
                    r_int_sts <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign app_msi_req  = r_msi_req;
    assign app_msi_num  = r_msi_num;
    assign app_msi_tc   = 3'(MSI_TC);
    assign app_int_sts  = r_int_sts;
    assign irq_pending  = r_pending;
    assign msi_sent_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_altpcierd_irq_msi_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_altpcierd_irq_msi_gen
//  Description : Directed self-checking bench for altpcierd_irq_msi_gen
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_altpcierd_irq_msi_gen;

    logic        pld_clk = 1'b0;
    logic        rstn;
    logic [3:0]  irq_src;
    logic [3:0]  irq_clr;
    logic [15:0] cfg_msicsr;
    logic [15:0] cfg_prmcsr;
    logic        app_msi_req;
    logic        app_msi_ack;
    logic [4:0]  app_msi_num;
    logic [2:0]  app_msi_tc;
    logic        app_int_sts;
    logic        app_int_ack;
    logic [3:0]  irq_pending;
    logic [15:0] msi_sent_cnt;

    int checks = 0;
    int errors = 0;
    int idle;

    altpcierd_irq_msi_gen #(
        .NUM_SRC    (4),
        .MSI_TC     (3),
        .GAP_CYCLES (4)
    ) dut (
        .pld_clk      (pld_clk),
        .rstn         (rstn),
        .irq_src      (irq_src),
        .irq_clr      (irq_clr),
        .cfg_msicsr   (cfg_msicsr),
        .cfg_prmcsr   (cfg_prmcsr),
        .app_msi_req  (app_msi_req),
        .app_msi_ack  (app_msi_ack),
        .app_msi_num  (app_msi_num),
        .app_msi_tc   (app_msi_tc),
        .app_int_sts  (app_int_sts),
        .app_int_ack  (app_int_ack),
        .irq_pending  (irq_pending),
        .msi_sent_cnt (msi_sent_cnt)
    );

    always #5 pld_clk = ~pld_clk;

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
    task automatic step();
        @(posedge pld_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        step();
    endtask

    initial begin
        rstn = 1'b0; irq_src = '0; irq_clr = '0;
        cfg_msicsr = '0; cfg_prmcsr = '0;
        app_msi_ack = 1'b0; app_int_ack = 1'b0;
        step();

        // Reset state
        chk("rst_req",  {31'd0, app_msi_req}, 32'd0);
        chk("rst_num",  {27'd0, app_msi_num}, 32'd0);
        chk("rst_tc",   {29'd0, app_msi_tc},  32'd3);
        chk("rst_sts",  {31'd0, app_int_sts}, 32'd0);
        chk("rst_pend", {28'd0, irq_pending}, 32'd0);
        chk("rst_cnt",  {16'd0, msi_sent_cnt}, 32'd0);
        rstn = 1'b1;
        step();

        // MSI, MME=2: src2 -> vector 2, request two cycles after the pulse
        cfg_msicsr = 16'h0021; cfg_prmcsr = 16'h0004;
        irq_src = 4'b0100;
        step();
        irq_src = '0;
        chk("t1_pend", {28'd0, irq_pending}, 32'h4);
        chk("t1_req_early", {31'd0, app_msi_req}, 32'd0);
        step();
        chk("t1_req", {31'd0, app_msi_req}, 32'd1);
        chk("t1_num", {27'd0, app_msi_num}, 32'd2);
        step(); step();
        chk("t1_req_hold", {31'd0, app_msi_req}, 32'd1);
        app_msi_ack = 1'b1;
        step();
        app_msi_ack = 1'b0;
        chk("t1_req_drop", {31'd0, app_msi_req}, 32'd0);
        chk("t1_cnt", {16'd0, msi_sent_cnt}, 32'd1);
        chk("t1_pend_clr", {28'd0, irq_pending}, 32'd0);

        // MME=0: src1 and src3 together, served src1 first, both on vector 0
        do_reset();
        cfg_msicsr = 16'h0001; cfg_prmcsr = 16'h0004;
        irq_src = 4'b1010;
        step();
        irq_src = '0;
        step();
        chk("t2_req1", {31'd0, app_msi_req}, 32'd1);
        chk("t2_num1", {27'd0, app_msi_num}, 32'd0);
        app_msi_ack = 1'b1;
        step();
        app_msi_ack = 1'b0;
        chk("t2_pend_after1", {28'd0, irq_pending}, 32'h8);
        idle = 0;
        while (!app_msi_req && idle < 20) begin
            idle++;
            step();
        end
        chk("t2_req2", {31'd0, app_msi_req}, 32'd1);
        chk("t2_gap_ge4", {31'd0, idle >= 4}, 32'd1);
        chk("t2_num2", {27'd0, app_msi_num}, 32'd0);
        app_msi_ack = 1'b1;
        step();
        app_msi_ack = 1'b0;
        chk("t2_pend_after2", {28'd0, irq_pending}, 32'd0);
        chk("t2_cnt", {16'd0, msi_sent_cnt}, 32'd2);

        // Legacy INTx full cycle on src0
        do_reset();
        cfg_msicsr = 16'h0000; cfg_prmcsr = 16'h0000;
        irq_src = 4'b0001;
        step();
        irq_src = '0;
        step();
        chk("t3_sts_on", {31'd0, app_int_sts}, 32'd1);
        chk("t3_no_req", {31'd0, app_msi_req}, 32'd0);
        app_int_ack = 1'b1;
        step();
        app_int_ack = 1'b0;
        chk("t3_sts_held", {31'd0, app_int_sts}, 32'd1);
        irq_clr = 4'b0001;
        step();
        irq_clr = '0;
        chk("t3_pend_clr", {28'd0, irq_pending}, 32'd0);
        step();
        chk("t3_sts_off", {31'd0, app_int_sts}, 32'd0);
        app_int_ack = 1'b1;
        step();
        app_int_ack = 1'b0;
        step(); step(); step();
        chk("t3_idle_req", {31'd0, app_msi_req}, 32'd0);
        chk("t3_idle_sts", {31'd0, app_int_sts}, 32'd0);
        chk("t3_cnt", {16'd0, msi_sent_cnt}, 32'd0);

        // MSI disabled mid-request: held to ack, remaining source goes INTx
        do_reset();
        cfg_msicsr = 16'h0001; cfg_prmcsr = 16'h0004;
        irq_src = 4'b0011;
        step();
        irq_src = '0;
        step();
        chk("t4_req", {31'd0, app_msi_req}, 32'd1);
        cfg_msicsr = 16'h0000;
        step(); step();
        chk("t4_req_held", {31'd0, app_msi_req}, 32'd1);
        app_msi_ack = 1'b1;
        step();
        app_msi_ack = 1'b0;
        chk("t4_req_drop", {31'd0, app_msi_req}, 32'd0);
        chk("t4_pend", {28'd0, irq_pending}, 32'h2);
        for (int i = 0; i < 8; i++) step();
        chk("t4_no_msi", {31'd0, app_msi_req}, 32'd0);
        chk("t4_intx", {31'd0, app_int_sts}, 32'd1);
        chk("t4_cnt", {16'd0, msi_sent_cnt}, 32'd1);

        // INTx active, MSI enabled mid-way: deassert then MSI for pending src2
        do_reset();
        cfg_msicsr = 16'h0000; cfg_prmcsr = 16'h0004;
        irq_src = 4'b0100;
        step();
        irq_src = '0;
        step();
        chk("t5_sts_on", {31'd0, app_int_sts}, 32'd1);
        app_int_ack = 1'b1;
        step();
        app_int_ack = 1'b0;
        cfg_msicsr = 16'h0021;
        step();
        chk("t5_sts_off", {31'd0, app_int_sts}, 32'd0);
        chk("t5_no_req_yet", {31'd0, app_msi_req}, 32'd0);
        app_int_ack = 1'b1;
        step();
        app_int_ack = 1'b0;
        step();
        chk("t5_req", {31'd0, app_msi_req}, 32'd1);
        chk("t5_num", {27'd0, app_msi_num}, 32'd2);
        chk("t5_sts_excl", {31'd0, app_int_sts}, 32'd0);

        // INTx disabled, MSI off: event parks; enabling MSI with MME=1 gives vector 1
        do_reset();
        cfg_msicsr = 16'h0000; cfg_prmcsr = 16'h0404;
        irq_src = 4'b1000;
        step();
        irq_src = '0;
        step(); step();
        chk("t6_no_req", {31'd0, app_msi_req}, 32'd0);
        chk("t6_no_sts", {31'd0, app_int_sts}, 32'd0);
        chk("t6_pend", {28'd0, irq_pending}, 32'h8);
        cfg_msicsr = 16'h0011;
        step();
        chk("t6_req", {31'd0, app_msi_req}, 32'd1);
        chk("t6_num", {27'd0, app_msi_num}, 32'd1);
        app_msi_ack = 1'b1;
        step();
        app_msi_ack = 1'b0;
        for (int i = 0; i < 8; i++) step();

        // MME=7 saturates to 32 vectors: src3 -> vector 3
        cfg_msicsr = 16'h0071;
        irq_src = 4'b1000;
        step();
        irq_src = '0;
        step();
        chk("t7_req", {31'd0, app_msi_req}, 32'd1);
        chk("t7_num", {27'd0, app_msi_num}, 32'd3);

        // Asynchronous reset mid-request, observed before any clock edge
        rstn = 1'b0;
        #2;
        chk("t8_req", {31'd0, app_msi_req}, 32'd0);
        chk("t8_num", {27'd0, app_msi_num}, 32'd0);
        chk("t8_pend", {28'd0, irq_pending}, 32'd0);
        chk("t8_cnt", {16'd0, msi_sent_cnt}, 32'd0);
        step();
        rstn = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
